steer_arbiter: RTL and testbench

- Shares one angle-control datapath (target_angle / angle_update / angle_done handshake, encoder path selected by a one-hot mux) among NUM_REQ steering requesters.
- Buffers per-requester target angles, picks a winner round-robin, switches the mux, waits a settle time, and then issues the update.
- Waits for completion, or times out, and reports per-requester done/timeout pulses.
- Sits between the FPGA subsystem register interface and the shared PWM/angle controller.

---
 rtl/steer_arbiter_pkg.sv | 40 ++++
 rtl/steer_rr_pick.sv | 35 +++
 rtl/steer_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_steer_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/steer_arbiter_pkg.sv
// steer_arbiter shared package: FSM state encoding, width defaults
// and the round-robin / fixed-priority winner select function.
package steer_arbiter_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t SELECT  = 3'd1;
  localparam state_t ISSUE   = 3'd2;
  localparam state_t WAIT    = 3'd3;
  localparam state_t RELEASE = 3'd4;

  localparam int ANGLE_W_DEF = 12;
  localparam int MAX_REQ     = 8;

  // Returns {valid, index}. Scans n slots starting at ptr
  // (or at 0 when fixed is set) and keeps the nearest hit.
  function automatic logic [3:0] pick_next(
    input logic [MAX_REQ-1:0] pend,
    input logic [2:0]         ptr,
    input int                 n,
    input logic               fixed
  );
    logic [3:0] res;
    int         base;
    int         idx;
    res  = '0;
    base = fixed ? 0 : int'(ptr);
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (base + k) % n;
        if (pend[idx[2:0]]) begin
          res = {1'b1, idx[2:0]};
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/steer_rr_pick.sv
// steer_rr_pick: combinational winner select for steer_arbiter.
// STEER_ARB_FIXED_PRIO_EN selects lowest-index priority instead of RR.
module steer_rr_pick
  import steer_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [2:0]         rr_ptr,
  output logic [2:0]         winner,
  output logic               valid
);

  logic [MAX_REQ-1:0] pend_ext;
  logic [3:0]         res;
  logic               fixed_prio;

`ifdef STEER_ARB_FIXED_PRIO_EN
  assign fixed_prio = 1'b1;
`else
  assign fixed_prio = 1'b0;
`endif

  // Widen the pending vector to the function's fixed width.
  always_comb begin
    pend_ext              = '0;
    pend_ext[NUM_REQ-1:0] = pending;
  end

  assign res    = pick_next(pend_ext, rr_ptr,
                            NUM_REQ, fixed_prio);
  assign winner = res[2:0];
  assign valid  = res[3];

endmodule

// File: rtl/steer_arbiter.sv
// steer_arbiter: shares one angle controller among NUM_REQ requesters.
// Build macro STEER_ARB_FIXED_PRIO_EN: fixed priority, requester 0 first.
module steer_arbiter
  import steer_arbiter_pkg::*;
#(
  parameter int          NUM_REQ        = 4,
  parameter int          ANGLE_W        = ANGLE_W_DEF,
  parameter int          SETTLE_CYCLES  = 256,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ANGLE_W-1:0] req_angle,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         req_timeout,
  output logic [NUM_REQ-1:0]         pending,
  output logic                       busy,
  output logic [2:0]                 active_id,
  output logic [NUM_REQ-1:0]         mux_sel,
  output logic [ANGLE_W-1:0]         target_angle,
  output logic                       angle_update,
  input  logic                       angle_done
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [SW-1:0] S_LAST =
    SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 24'd1);

  state_t state_q;
  state_t state_d;

  logic [ANGLE_W-1:0] abuf [NUM_REQ];
  logic [ANGLE_W-1:0] sel_angle;
  logic [NUM_REQ-1:0] pend_d;
  logic [2:0]         rr_ptr;
  logic [SW-1:0]      scnt;
  logic [TW-1:0]      tcnt;
  logic               armed;
  logic               timed_out;
  logic [2:0]         win;
  logic               win_vld;
  logic               grant;
  logic               complete;
  logic               expire;

  steer_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .winner  (win),
    .valid   (win_vld)
  );

  assign grant    = (state_q == IDLE) && win_vld;
  assign complete = armed && angle_done;
  assign expire   = (tcnt == T_LAST);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) state_d = SELECT;
      end
      SELECT: begin
        if (scnt == S_LAST) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (complete || expire) state_d = RELEASE;
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs: strobes and completion pulses.
  always_comb begin
    busy         = (state_q != IDLE);
    angle_update = (state_q == ISSUE);
    req_done     = '0;
    req_timeout  = '0;
    if (state_q == RELEASE) begin
      if (timed_out) begin
        req_timeout = NUM_REQ'(1) << active_id;
      end else begin
        req_done = NUM_REQ'(1) << active_id;
      end
    end
  end

  // Pending update: grant clears, a new strobe re-sets.
  always_comb begin
    pend_d = pending;
    if (grant) begin
      pend_d = pend_d & ~(NUM_REQ'(1) << win);
    end
    pend_d = pend_d | req;
  end

  // Buffered angle of the current winner.
  always_comb begin
    sel_angle = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == 3'(i)) sel_angle = abuf[i];
    end
  end

  // Request buffers, grant registers, counters and flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending      <= '0;
      rr_ptr       <= '0;
      scnt         <= '0;
      tcnt         <= '0;
      armed        <= 1'b0;
      timed_out    <= 1'b0;
      active_id    <= '0;
      mux_sel      <= '0;
      target_angle <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        abuf[i] <= '0;
      end
    end else begin
      pending <= pend_d;

      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i]) begin
          abuf[i] <= req_angle[i*ANGLE_W +: ANGLE_W];
        end
      end

      if (grant) begin
        active_id    <= win;
        mux_sel      <= NUM_REQ'(1) << win;
        target_angle <= sel_angle;
`ifndef STEER_ARB_FIXED_PRIO_EN
        rr_ptr <= (win == 3'(NUM_REQ - 1)) ?
                  3'd0 : win + 3'd1;
`endif
      end

      if (state_q == SELECT) begin
        scnt <= scnt + 1'b1;
      end else begin
        scnt <= '0;
      end

      if (state_q == WAIT) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end

      if (state_q == ISSUE) begin
        armed <= 1'b0;
      end else if (state_q == WAIT && !angle_done) begin
        armed <= 1'b1;
      end

      if (state_q == WAIT) begin
        timed_out <= !complete;
      end

      if (state_q == WAIT && (complete || expire)) begin
        mux_sel <= '0;
      end
    end
  end

endmodule

// File: tb/tb_steer_arbiter.sv
// tb_steer_arbiter: directed scoreboard bench for steer_arbiter.
// Honours STEER_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_steer_arbiter;

  localparam int          N  = 4;
  localparam int          AW = 12;
  localparam int          S  = 16;
  localparam logic [23:0] T  = 24'd100;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_angle;
  logic [N-1:0]    req_done;
  logic [N-1:0]    req_timeout;
  logic [N-1:0]    pending;
  logic            busy;
  logic [2:0]      active_id;
  logic [N-1:0]    mux_sel;
  logic [AW-1:0]   target_angle;
  logic            angle_update;
  logic            angle_done;

  steer_arbiter #(
    .NUM_REQ        (N),
    .ANGLE_W        (AW),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_angle    (req_angle),
    .req_done     (req_done),
    .req_timeout  (req_timeout),
    .pending      (pending),
    .busy         (busy),
    .active_id    (active_id),
    .mux_sel      (mux_sel),
    .target_angle (target_angle),
    .angle_update (angle_update),
    .angle_done   (angle_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int id;
    int angle;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int id, input int ang);
    req[id] = 1'b1;
    req_angle[id*AW +: AW] = AW'(ang);
  endtask

  task automatic fire();
    step();
    req = '0;
  endtask

  // Wait for the next update, check it against the scoreboard,
  // drive angle_done as asked and check the release pulse.
  task automatic serve(input int hold_hi, input int low_cyc,
                       input bit to, input int req_cyc);
    exp_t e;
    int   u;
    int   r;
    bit   seen;
    bit   early;
    seen = 1'b0;
    for (int i = 0; i < S + 60; i++) begin
      if (angle_update) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("update_seen", 32'(seen), 1);
    if (!seen) return;
    e = sb.pop_front();
    u = cyc;
    if (req_cyc >= 0) begin
      chk("update_latency", u - req_cyc, S + 2);
    end
    chk("active_id", 32'(active_id), e.id);
    chk("mux_sel", 32'(mux_sel), 1 << e.id);
    chk("target_angle", 32'(target_angle), e.angle);
    early = 1'b0;
    angle_done = (hold_hi > 0);
    step();
    chk("update_1cyc", 32'(angle_update), 0);
    if ((req_done | req_timeout) != 0) early = 1'b1;
    for (int i = 1; i < hold_hi; i++) begin
      step();
      if ((req_done | req_timeout) != 0) early = 1'b1;
    end
    angle_done = 1'b0;
    if (!to) begin
      for (int i = 0; i < low_cyc; i++) begin
        step();
        if ((req_done | req_timeout) != 0) early = 1'b1;
      end
      angle_done = 1'b1;
      r = cyc;
    end else begin
      r = u + int'(T);
    end
    chk("no_early_pulse", 32'(early), 0);
    seen = 1'b0;
    for (int i = 0; i < int'(T) + 20; i++) begin
      step();
      if ((req_done | req_timeout) != 0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("pulse_seen", 32'(seen), 1);
    if (!seen) return;
    chk("pulse_cycle", cyc, r + 1);
    if (to) begin
      chk("timeout_vec", 32'(req_timeout), 1 << e.id);
      chk("timeout_no_done", 32'(req_done), 0);
    end else begin
      chk("done_vec", 32'(req_done), 1 << e.id);
      chk("done_no_timeout", 32'(req_timeout), 0);
    end
    chk("release_mux_zero", 32'(mux_sel), 0);
    chk("release_angle_hold", 32'(target_angle), e.angle);
    step();
    chk("pulse_1cyc", 32'(req_done | req_timeout), 0);
    chk("busy_drop", 32'(busy), 0);
    chk("idle_mux_zero", 32'(mux_sel), 0);
  endtask

  initial begin : main
    int  rc;
    bit  seen;
    bit  noisy;

    reset      = 1'b1;
    req        = '0;
    req_angle  = '0;
    angle_done = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mux", 32'(mux_sel), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_update", 32'(angle_update), 0);
    chk("rst_pulses", 32'(req_done | req_timeout), 0);
    chk("rst_id", 32'(active_id), 0);
    chk("rst_angle", 32'(target_angle), 0);
    reset = 1'b0;
    step();

    // Single request.
    set_req(2, 300);
    rc = cyc;
    sb.push_back(exp_t'{2, 300});
    fire();
    chk("single_pending", 32'(pending), 4'b0100);
    serve(0, 50, 1'b0, rc);

    // Move the RR pointer through the wrap back to 0.
    set_req(3, 7);
    sb.push_back(exp_t'{3, 7});
    fire();
    serve(0, 20, 1'b0, -1);

    // All four at once.
    set_req(0, 10);
    set_req(1, 20);
    set_req(2, 30);
    set_req(3, 40);
    rc = cyc;
    sb.push_back(exp_t'{0, 10});
    sb.push_back(exp_t'{1, 20});
    sb.push_back(exp_t'{2, 30});
    sb.push_back(exp_t'{3, 40});
    fire();
    chk("all_pending", 32'(pending), 4'b1111);
    serve(0, 20, 1'b0, rc);
    serve(0, 20, 1'b0, -1);
    serve(0, 20, 1'b0, -1);
    serve(0, 20, 1'b0, -1);

    // Re-request 1 and 0.
    set_req(1, 11);
    set_req(0, 12);
    sb.push_back(exp_t'{0, 12});
    sb.push_back(exp_t'{1, 11});
    fire();
    serve(0, 20, 1'b0, -1);
    serve(0, 20, 1'b0, -1);

    // 3 and 1 together.
    set_req(3, 13);
    set_req(1, 14);
`ifdef STEER_ARB_FIXED_PRIO_EN
    sb.push_back(exp_t'{1, 14});
    sb.push_back(exp_t'{3, 13});
`else
    sb.push_back(exp_t'{3, 13});
    sb.push_back(exp_t'{1, 14});
`endif
    fire();
    serve(0, 20, 1'b0, -1);
    serve(0, 20, 1'b0, -1);

    // Stale done held high through ISSUE.
    chk("stale_level", 32'(angle_done), 1);
    set_req(0, 55);
    sb.push_back(exp_t'{0, 55});
    fire();
    serve(10, 5, 1'b0, -1);

    // Timeout.
    set_req(1, 77);
    sb.push_back(exp_t'{1, 77});
    fire();
    serve(0, 0, 1'b1, -1);

    // Overwrite while another grant is active.
    set_req(0, 1);
    sb.push_back(exp_t'{0, 1});
    fire();
    step();
    step();
    set_req(1, 100);
    fire();
    set_req(1, 200);
    fire();
    chk("overwrite_pending", 32'(pending), 4'b0010);
    sb.push_back(exp_t'{1, 200});
    serve(0, 20, 1'b0, -1);
    serve(0, 20, 1'b0, -1);

    // Requeue in the grant cycle.
    set_req(1, 500);
    rc = cyc;
    sb.push_back(exp_t'{1, 500});
    fire();
    set_req(1, 600);
    fire();
    chk("requeue_pending", 32'(pending), 4'b0010);
    chk("requeue_busy", 32'(busy), 1);
    sb.push_back(exp_t'{1, 600});
    serve(0, 20, 1'b0, rc);
    serve(0, 20, 1'b0, -1);

    // Reset in the middle of WAIT.
    set_req(2, 900);
    fire();
    seen = 1'b0;
    for (int i = 0; i < S + 60; i++) begin
      if (angle_update) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("mid_update_seen", 32'(seen), 1);
    chk("mid_angle", 32'(target_angle), 900);
    angle_done = 1'b0;
    for (int i = 0; i < 5; i++) step();
    set_req(3, 5);
    fire();
    chk("mid_pending", 32'(pending), 4'b1000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_mux", 32'(mux_sel), 0);
    chk("mid_rst_pending", 32'(pending), 0);
    chk("mid_rst_angle", 32'(target_angle), 0);
    chk("mid_rst_id", 32'(active_id), 0);
    chk("mid_rst_pulses", 32'(req_done | req_timeout), 0);
    noisy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (busy || (req_done | req_timeout) != 0) noisy = 1'b1;
    end
    chk("post_rst_quiet", 32'(noisy), 0);
    set_req(0, 321);
    rc = cyc;
    sb.push_back(exp_t'{0, 321});
    fire();
    serve(0, 20, 1'b0, rc);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
